// File: rtl/dm_dmi_target.sv
// dm_dmi_target: Debug Module front end fed by the JTAG DTM.
// Decodes DMI requests against a minimal debug register set (data0, dmcontrol,
// dmstatus, abstractcs, command). It drives halt/resume requests to one hart
// and runs Access-Register abstract commands over a req/ack register port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   dmi_req_*           DTM request channel (valid/ready, addr, data, op)
//   dmi_resp_*          response channel back to the DTM (valid/ready, data, op)
//   hart_halt_req       level, mirrors dmcontrol.haltreq
//   hart_resume_req     held until hart_resume_ack
//   hart_resume_ack     one-cycle ack from the hart
//   hart_halted         hart is in debug mode
//   ndmreset            mirrors dmcontrol.ndmreset
//   reg_req_*           abstract register access, one-cycle valid pulse
//   reg_ack, reg_rdata  access completion; rdata is valid with ack
module dm_dmi_target #(
  parameter int ABITS     = 7,
  parameter int DATACOUNT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dmi_req_valid,
  output logic             dmi_req_ready,
  input  logic [ABITS-1:0] dmi_req_addr,
  input  logic [31:0]      dmi_req_data,
  input  logic [1:0]       dmi_req_op,
  output logic             dmi_resp_valid,
  input  logic             dmi_resp_ready,
  output logic [31:0]      dmi_resp_data,
  output logic [1:0]       dmi_resp_op,
  output logic             hart_halt_req,
  output logic             hart_resume_req,
  input  logic             hart_resume_ack,
  input  logic             hart_halted,
  output logic             ndmreset,
  output logic             reg_req_valid,
  output logic             reg_req_write,
  output logic [15:0]      reg_req_regno,
  output logic [31:0]      reg_req_wdata,
  input  logic             reg_ack,
  input  logic [31:0]      reg_rdata
);

  localparam logic [ABITS-1:0] AD_DATA0  = ABITS'(32'h04);
  localparam logic [ABITS-1:0] AD_DMCTL  = ABITS'(32'h10);
  localparam logic [ABITS-1:0] AD_DMSTAT = ABITS'(32'h11);
  localparam logic [ABITS-1:0] AD_ACS    = ABITS'(32'h16);
  localparam logic [ABITS-1:0] AD_CMD    = ABITS'(32'h17);

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef enum logic {D_IDLE, D_RESP} dstate_t;
  typedef enum logic [1:0] {A_IDLE, A_REQ, A_WAIT} astate_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_resp_t;

  dstate_t   dstate_q, dstate_d;
  astate_t   astate_q, astate_d;
  dmi_resp_t resp_q;

  logic        dmactive_q, haltreq_q, ndmreset_q;
  logic        resume_req_q, resumeack_q;
  logic [31:0] data0_q;
  logic [2:0]  cmderr_q, cmderr_d;
  logic        req_write_q;
  logic [15:0] req_regno_q;
  logic [31:0] req_wdata_q;

  logic        accept, wr_en, busy;
  logic        wr_data0, wr_dmctl, wr_acs, wr_cmd;
  logic        dm_clr, dm_on;
  logic [31:0] rdata;
  logic [2:0]  new_err;
  logic        cmd_start;

  assign accept = dmi_req_valid && dmi_req_ready;
  assign wr_en  = accept && (dmi_req_op == OP_WR);
  assign busy   = (astate_q != A_IDLE);

  // dmcontrol is always writable; everything else is frozen while inactive
  assign wr_dmctl = wr_en && (dmi_req_addr == AD_DMCTL);
  assign wr_data0 = wr_en && dmactive_q && (dmi_req_addr == AD_DATA0);
  assign wr_acs   = wr_en && dmactive_q && (dmi_req_addr == AD_ACS);
  assign wr_cmd   = wr_en && dmactive_q && (dmi_req_addr == AD_CMD);

  // The written dmactive bit decides: 0 wipes DM state, 1 lets the other
  // fields of the same write take effect (a single activate+halt write works).
  assign dm_clr = wr_dmctl && !dmi_req_data[0];
  assign dm_on  = wr_dmctl &&  dmi_req_data[0];

  // ---------------- DMI request/response FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) dstate_q <= D_IDLE;
    else     dstate_q <= dstate_d;
  end

  always_comb begin
    dstate_d = dstate_q;
    case (dstate_q)
      D_IDLE:  if (accept) dstate_d = D_RESP;
      D_RESP:  if (dmi_resp_ready) dstate_d = D_IDLE;
      default: dstate_d = D_IDLE;
    endcase
  end

  assign dmi_req_ready  = (dstate_q == D_IDLE);
  assign dmi_resp_valid = (dstate_q == D_RESP);
  assign dmi_resp_data  = resp_q.data;
  assign dmi_resp_op    = resp_q.op;

  // Read mux; unmapped and write-only registers return 0
  always_comb begin
    rdata = 32'h0;
    case (dmi_req_addr)
      AD_DATA0: rdata = data0_q;
      AD_DMCTL: begin
        rdata[31] = haltreq_q;
        rdata[1]  = ndmreset_q;
        rdata[0]  = dmactive_q;
      end
      AD_DMSTAT: begin
        rdata[3:0] = 4'd2;
        rdata[7]   = 1'b1;
        rdata[8]   = hart_halted;
        rdata[9]   = hart_halted;
        rdata[10]  = !hart_halted;
        rdata[11]  = !hart_halted;
        rdata[16]  = resumeack_q;
        rdata[17]  = resumeack_q;
      end
      AD_ACS: begin
        rdata[3:0]  = 4'(DATACOUNT);
        rdata[10:8] = cmderr_q;
        rdata[12]   = busy;
      end
      default: rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= '0;
    end else if (accept) begin
      resp_q.data <= (dmi_req_op == OP_RD) ? rdata : 32'h0;
      resp_q.op   <= (dmi_req_op == OP_RSV) ? 2'd2 : 2'd0;
    end
  end

  // ---------------- dmcontrol / resume ----------------
  always_ff @(posedge clk) begin
    if (rst)           dmactive_q <= 1'b0;
    else if (wr_dmctl) dmactive_q <= dmi_req_data[0];
  end

  always_ff @(posedge clk) begin
    if (rst || dm_clr) begin
      haltreq_q  <= 1'b0;
      ndmreset_q <= 1'b0;
    end else if (dm_on) begin
      haltreq_q  <= dmi_req_data[31];
      ndmreset_q <= dmi_req_data[1];
    end
  end

  // resumereq together with haltreq is not a resume
  always_ff @(posedge clk) begin
    if (rst || dm_clr) begin
      resume_req_q <= 1'b0;
      resumeack_q  <= 1'b0;
    end else if (dm_on && dmi_req_data[30] && !dmi_req_data[31]) begin
      resume_req_q <= 1'b1;
      resumeack_q  <= 1'b0;
    end else if (resume_req_q && hart_resume_ack) begin
      resume_req_q <= 1'b0;
      resumeack_q  <= 1'b1;
    end
  end

  assign hart_halt_req   = haltreq_q;
  assign hart_resume_req = resume_req_q;
  assign ndmreset        = ndmreset_q;

  // ---------------- abstract command decode ----------------
  always_comb begin
    new_err   = 3'd0;
    cmd_start = 1'b0;
    if (wr_cmd) begin
      if (busy)
        new_err = 3'd1;
      else if (cmderr_q != 3'd0)
        new_err = 3'd0;
      else if ((dmi_req_data[31:24] != 8'd0) ||
               (dmi_req_data[17] && (dmi_req_data[22:20] != 3'd2)))
        new_err = 3'd2;
      else if (!hart_halted)
        new_err = 3'd4;
      else if (dmi_req_data[17])
        cmd_start = 1'b1;
    end else if (wr_data0 && busy) begin
      new_err = 3'd1;
    end
  end

  // Sticky: errors only land on a clear cmderr, and beat a same-cycle W1C
  always_comb begin
    cmderr_d = cmderr_q;
    if (wr_acs) cmderr_d = cmderr_q & ~dmi_req_data[10:8];
    if ((new_err != 3'd0) && (cmderr_q == 3'd0)) cmderr_d = new_err;
  end

  always_ff @(posedge clk) begin
    if (rst || dm_clr) cmderr_q <= 3'd0;
    else               cmderr_q <= cmderr_d;
  end

  // ---------------- abstract FSM ----------------
  always_ff @(posedge clk) begin
    if (rst || dm_clr) astate_q <= A_IDLE;
    else               astate_q <= astate_d;
  end

  always_comb begin
    astate_d = astate_q;
    case (astate_q)
      A_IDLE:  if (cmd_start) astate_d = A_REQ;
      A_REQ:   astate_d = A_WAIT;
      A_WAIT:  if (reg_ack) astate_d = A_IDLE;
      default: astate_d = A_IDLE;
    endcase
  end

  // Request fields are captured at issue so data0 may change afterwards
  always_ff @(posedge clk) begin
    if (rst || dm_clr) begin
      req_write_q <= 1'b0;
      req_regno_q <= 16'h0;
      req_wdata_q <= 32'h0;
    end else if (cmd_start) begin
      req_write_q <= dmi_req_data[16];
      req_regno_q <= dmi_req_data[15:0];
      req_wdata_q <= data0_q;
    end
  end

  assign reg_req_valid = (astate_q == A_REQ);
  assign reg_req_write = req_write_q;
  assign reg_req_regno = req_regno_q;
  assign reg_req_wdata = req_wdata_q;

  // data0: DMI writes are dropped while busy; read commands load it on ack
  always_ff @(posedge clk) begin
    if (rst || dm_clr)
      data0_q <= 32'h0;
    else if ((astate_q == A_WAIT) && reg_ack && !req_write_q)
      data0_q <= reg_rdata;
    else if (wr_data0 && !busy)
      data0_q <= dmi_req_data;
  end

endmodule

// File: tb/tb_dm_dmi_target.sv
// Bench for dm_dmi_target: directed DMI transactions push expected responses
// into a queue; a monitor pops and compares on every response handshake.
// A small hart model acks abstract register requests.
module tb_dm_dmi_target;
  logic        clk = 1'b0;
  logic        rst;
  logic        dmi_req_valid, dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_resp_valid, dmi_resp_ready;
  logic [31:0] dmi_resp_data;
  logic [1:0]  dmi_resp_op;
  logic        hart_halt_req, hart_resume_req, hart_resume_ack, hart_halted;
  logic        ndmreset;
  logic        reg_req_valid, reg_req_write;
  logic [15:0] reg_req_regno;
  logic [31:0] reg_req_wdata;
  logic        reg_ack;
  logic [31:0] reg_rdata;

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];

  int          pulse_cnt = 0;
  logic        cap_w;
  logic [15:0] cap_regno;
  logic [31:0] cap_wdata;
  logic        ack_en = 1'b1;
  logic [31:0] rdata_val = 32'h0;

  always #5 clk = ~clk;

  dm_dmi_target #(.ABITS(7), .DATACOUNT(1)) dut (
    .clk(clk), .rst(rst),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
    .dmi_resp_data(dmi_resp_data), .dmi_resp_op(dmi_resp_op),
    .hart_halt_req(hart_halt_req), .hart_resume_req(hart_resume_req),
    .hart_resume_ack(hart_resume_ack), .hart_halted(hart_halted),
    .ndmreset(ndmreset),
    .reg_req_valid(reg_req_valid), .reg_req_write(reg_req_write),
    .reg_req_regno(reg_req_regno), .reg_req_wdata(reg_req_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (!rst && dmi_resp_valid && dmi_resp_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected: got data %h op %0d want none", dmi_resp_data, dmi_resp_op);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", dmi_resp_data, e[31:0]);
          chk("resp_op", {30'b0, dmi_resp_op}, {30'b0, e[33:32]});
        end
      end
    end
  end

  // Hart register-file model: ack three negedges after seeing the request
  initial begin
    forever begin
      @(negedge clk);
      if (reg_req_valid) begin
        pulse_cnt++;
        cap_w     = reg_req_write;
        cap_regno = reg_req_regno;
        cap_wdata = reg_req_wdata;
        if (ack_en) begin
          repeat (3) @(negedge clk);
          reg_ack   = 1'b1;
          reg_rdata = rdata_val;
          @(negedge clk);
          reg_ack   = 1'b0;
        end
      end
    end
  end

  // One DMI transaction; hold>0 stalls dmi_resp_ready for that many cycles
  task automatic dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                     input logic [31:0] ed, input logic [1:0] eop, input int hold = 0);
    int n;
    exp_q.push_back({eop, ed});
    @(negedge clk);
    dmi_req_valid  = 1'b1;
    dmi_req_addr   = a;
    dmi_req_data   = d;
    dmi_req_op     = op;
    dmi_resp_ready = (hold == 0);
    n = 0;
    while (!dmi_req_ready && n < 20) begin @(negedge clk); n++; end
    if (!dmi_req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_timeout: got 0 want 1");
    end
    @(negedge clk);
    dmi_req_valid = 1'b0;
    dmi_req_op    = 2'd0;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_valid", {31'b0, dmi_resp_valid}, 32'd1);
        chk("hold_data", dmi_resp_data, ed);
        chk("hold_req_ready", {31'b0, dmi_req_ready}, 32'd0);
        @(negedge clk);
      end
      @(posedge clk);
      #1 dmi_resp_ready = 1'b1;
      @(negedge clk);
    end
    n = 0;
    while (!(dmi_resp_valid && dmi_resp_ready) && n < 20) begin @(negedge clk); n++; end
    if (!(dmi_resp_valid && dmi_resp_ready)) begin
      total++; bad++;
      $display("FAIL resp_timeout: got no response want one");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dmi_req_valid = 1'b0; dmi_req_addr = '0; dmi_req_data = '0; dmi_req_op = '0;
    dmi_resp_ready = 1'b1;
    hart_resume_ack = 1'b0; hart_halted = 1'b0;
    reg_ack = 1'b0; reg_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, dmi_req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, dmi_resp_valid}, 32'd0);
    chk("rst_halt", {31'b0, hart_halt_req}, 32'd0);
    chk("rst_resume", {31'b0, hart_resume_req}, 32'd0);
    chk("rst_ndmreset", {31'b0, ndmreset}, 32'd0);
    chk("rst_reg_valid", {31'b0, reg_req_valid}, 32'd0);
    rst = 1'b0;

    // dmstatus after reset, hart running
    dmi(7'h11, 32'h0, 2'd1, 32'h00000C82, 2'd0);

    // activate + halt in one write
    dmi(7'h10, 32'h80000001, 2'd2, 32'h0, 2'd0);
    chk("halt_req", {31'b0, hart_halt_req}, 32'd1);
    dmi(7'h10, 32'h0, 2'd1, 32'h80000001, 2'd0);
    repeat (3) @(posedge clk);
    #1 hart_halted = 1'b1;
    dmi(7'h11, 32'h0, 2'd1, 32'h00000382, 2'd0);

    // abstract write of x5
    dmi(7'h04, 32'hDEADBEEF, 2'd2, 32'h0, 2'd0);
    dmi(7'h17, 32'h00230005, 2'd2, 32'h0, 2'd0);
    dmi(7'h16, 32'h0, 2'd1, 32'h00001001, 2'd0);
    repeat (8) @(posedge clk);
    #1;
    dmi(7'h16, 32'h0, 2'd1, 32'h00000001, 2'd0);
    chk("pulse_cnt1", pulse_cnt, 1);
    chk("cap_write", {31'b0, cap_w}, 32'd1);
    chk("cap_regno", {16'b0, cap_regno}, 32'd5);
    chk("cap_wdata", cap_wdata, 32'hDEADBEEF);

    // abstract read of x5, second command while busy
    rdata_val = 32'h12345678;
    dmi(7'h17, 32'h00220005, 2'd2, 32'h0, 2'd0);
    dmi(7'h17, 32'h00220005, 2'd2, 32'h0, 2'd0);
    repeat (8) @(posedge clk);
    #1;
    dmi(7'h04, 32'h0, 2'd1, 32'h12345678, 2'd0);
    dmi(7'h16, 32'h0, 2'd1, 32'h00000101, 2'd0);
    dmi(7'h16, 32'h00000700, 2'd2, 32'h0, 2'd0);
    dmi(7'h16, 32'h0, 2'd1, 32'h00000001, 2'd0);
    chk("pulse_cnt2", pulse_cnt, 2);
    chk("cap_read", {31'b0, cap_w}, 32'd0);

    // command while hart running, then unsupported command
    hart_halted = 1'b0;
    dmi(7'h17, 32'h00230005, 2'd2, 32'h0, 2'd0);
    dmi(7'h16, 32'h0, 2'd1, 32'h00000401, 2'd0);
    chk("no_pulse_running", pulse_cnt, 2);
    dmi(7'h16, 32'h00000700, 2'd2, 32'h0, 2'd0);
    dmi(7'h17, 32'h01000000, 2'd2, 32'h0, 2'd0);
    dmi(7'h16, 32'h0, 2'd1, 32'h00000201, 2'd0);
    dmi(7'h16, 32'h00000700, 2'd2, 32'h0, 2'd0);

    // reserved op, unmapped read, nop, write-only read
    dmi(7'h11, 32'h0, 2'd3, 32'h0, 2'd2);
    dmi(7'h20, 32'h0, 2'd1, 32'h0, 2'd0);
    dmi(7'h04, 32'h0, 2'd0, 32'h0, 2'd0);
    dmi(7'h17, 32'h0, 2'd1, 32'h0, 2'd0);

    // stalled response
    dmi(7'h11, 32'h0, 2'd1, 32'h00000C82, 2'd0, 5);

    // resume handshake
    hart_halted = 1'b1;
    dmi(7'h10, 32'h40000001, 2'd2, 32'h0, 2'd0);
    chk("resume_req", {31'b0, hart_resume_req}, 32'd1);
    chk("halt_dropped", {31'b0, hart_halt_req}, 32'd0);
    dmi(7'h11, 32'h0, 2'd1, 32'h00000382, 2'd0);
    @(negedge clk) hart_resume_ack = 1'b1;
    @(negedge clk) hart_resume_ack = 1'b0;
    chk("resume_req_drop", {31'b0, hart_resume_req}, 32'd0);
    hart_halted = 1'b0;
    dmi(7'h11, 32'h0, 2'd1, 32'h00030C82, 2'd0);

    // reset while in A_WAIT
    hart_halted = 1'b1;
    dmi(7'h10, 32'h40000001, 2'd2, 32'h0, 2'd0);
    dmi(7'h10, 32'h80000003, 2'd2, 32'h0, 2'd0);
    chk("pre_halt", {31'b0, hart_halt_req}, 32'd1);
    chk("pre_ndm", {31'b0, ndmreset}, 32'd1);
    chk("pre_resume", {31'b0, hart_resume_req}, 32'd1);
    ack_en = 1'b0;
    dmi(7'h17, 32'h00230005, 2'd2, 32'h0, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rr_reg_valid", {31'b0, reg_req_valid}, 32'd0);
    chk("rr_halt", {31'b0, hart_halt_req}, 32'd0);
    chk("rr_resume", {31'b0, hart_resume_req}, 32'd0);
    chk("rr_ndm", {31'b0, ndmreset}, 32'd0);
    chk("rr_req_ready", {31'b0, dmi_req_ready}, 32'd1);
    chk("rr_resp_valid", {31'b0, dmi_resp_valid}, 32'd0);
    rst = 1'b0;
    dmi(7'h10, 32'h0, 2'd1, 32'h0, 2'd0);
    dmi(7'h16, 32'h0, 2'd1, 32'h00000001, 2'd0);
    dmi(7'h04, 32'h0, 2'd1, 32'h0, 2'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
